fetch_resp: RTL and testbench

Responder end of the fetch request/instruction return interface. Accepts fetch PCs from the fetch controller and issues them to instruction memory. Collects in-order memory responses and returns instruction/PC pairs to decode via the active-low `inst_e_` strobe. Sits between fetch control and the instruction memory/cache port, and owns outstanding-request tracking, backpressure and flush discard.

---
 rtl/fetch_resp.sv | 157 +++++++++++++++
 tb/tb_fetch_resp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_resp.sv
// Fetch responder: issues fetch PCs to instruction memory and returns in-order instruction/PC pairs to decode.
// Define FETCH_RESP_MISALIGN_CHK_EN to add the inst_misalign output and bypass memory for misaligned PCs.
module fetch_resp #(
    parameter int ADDR     = 32,
    parameter int INST     = 32,
    parameter int OUTSTAND = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req_,
    input  logic [ADDR-1:0] fetch_pc,
    output logic            fetch_busy,
    output logic            inst_e_,
    output logic [INST-1:0] inst,
    output logic [ADDR-1:0] inst_pc,
`ifdef FETCH_RESP_MISALIGN_CHK_EN
    output logic            inst_misalign,
`endif
    input  logic            dec_stall,
    input  logic            wb_flush_,
    output logic            mem_req_,
    output logic [ADDR-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [INST-1:0] mem_rdata
);

    localparam int PW = $clog2(OUTSTAND);
    localparam int CW = PW + 1;

    logic            slot_valid;
    logic [ADDR-1:0] slot_pc;
    logic [CW-1:0]   inflight, kill, rsp_count, occ, inflight_nxt;
    logic [PW-1:0]   pc_wr, pc_rd, rsp_wr, rsp_rd;
    logic [ADDR-1:0] pc_mem [OUTSTAND];
    logic [INST-1:0] rsp_inst_mem [OUTSTAND];
    logic [ADDR-1:0] rsp_pc_mem [OUTSTAND];
    logic [INST-1:0] hold_inst, rsp_inst_w;
    logic [ADDR-1:0] hold_pc, rsp_pc_w;
    logic            flush, accept, mem_accept, grant, resp_ok, resp_live, resp_killed;
    logic            rsp_push, rsp_pop, rsp_empty;
    logic            mis_accept, mis_valid, mis_push;

    assign flush       = ~wb_flush_;
    assign accept      = ~fetch_req_ & ~fetch_busy;
    assign mem_accept  = accept & ~mis_accept;
    assign grant       = slot_valid & mem_gnt;
    assign resp_ok     = mem_rvalid & (inflight != '0);
    assign resp_killed = resp_ok & (kill != '0);
    assign resp_live   = resp_ok & (kill == '0) & ~flush;
    assign rsp_empty   = (rsp_count == '0);
    assign rsp_pop     = ~rsp_empty & ~dec_stall;
    assign rsp_push    = resp_live | mis_push;

    // Killed requests stay in inflight until they return, so they keep holding a credit.
    assign occ          = CW'(slot_valid) + CW'(mis_valid) + inflight + rsp_count;
    assign inflight_nxt = inflight + CW'(grant) - CW'(resp_ok);

    assign fetch_busy = (occ == CW'(OUTSTAND)) | slot_valid | mis_valid | flush;
    assign mem_req_   = ~slot_valid;
    assign mem_addr   = slot_pc;
    assign inst_e_    = rsp_empty;
    assign inst       = rsp_empty ? hold_inst : rsp_inst_mem[rsp_rd];
    assign inst_pc    = rsp_empty ? hold_pc : rsp_pc_mem[rsp_rd];

`ifdef FETCH_RESP_MISALIGN_CHK_EN
    logic [ADDR-1:0] mis_pc;
    logic            rsp_mis_mem [OUTSTAND];
    logic            hold_mis;

    assign mis_accept = accept & (fetch_pc[1:0] != 2'b00);
    // Waiting for an empty memory path keeps the bypassed entry in program order.
    assign mis_push   = mis_valid & (inflight == '0) & ~slot_valid & ~flush;
    assign rsp_inst_w = mis_push ? '0 : mem_rdata;
    assign rsp_pc_w   = mis_push ? mis_pc : pc_mem[pc_rd];
    assign inst_misalign = rsp_empty ? hold_mis : rsp_mis_mem[rsp_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_valid <= 1'b0;
            mis_pc    <= '0;
            hold_mis  <= 1'b0;
        end else begin
            hold_mis <= inst_misalign;
            if (flush || mis_push) begin
                mis_valid <= 1'b0;
            end else if (mis_accept) begin
                mis_valid <= 1'b1;
                mis_pc    <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mis_mem[rsp_wr] <= mis_push;
    end
`else
    assign mis_accept = 1'b0;
    assign mis_valid  = 1'b0;
    assign mis_push   = 1'b0;
    assign rsp_inst_w = mem_rdata;
    assign rsp_pc_w   = pc_mem[pc_rd];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= 1'b0;
            slot_pc    <= '0;
            inflight   <= '0;
            kill       <= '0;
            pc_wr      <= '0;
            pc_rd      <= '0;
            rsp_wr     <= '0;
            rsp_rd     <= '0;
            rsp_count  <= '0;
            hold_inst  <= '0;
            hold_pc    <= '0;
        end else begin
            hold_inst <= inst;
            hold_pc   <= inst_pc;
            inflight  <= inflight_nxt;
            kill      <= flush ? inflight_nxt : kill - CW'(resp_killed);
            if (mem_accept) begin
                slot_valid <= 1'b1;
                slot_pc    <= fetch_pc;
            end else if (grant || flush) begin
                slot_valid <= 1'b0;
            end
            if (flush) begin
                pc_wr     <= '0;
                pc_rd     <= '0;
                rsp_wr    <= '0;
                rsp_rd    <= '0;
                rsp_count <= '0;
            end else begin
                if (grant)     pc_wr  <= pc_wr + PW'(1);
                if (resp_live) pc_rd  <= pc_rd + PW'(1);
                if (rsp_push)  rsp_wr <= rsp_wr + PW'(1);
                if (rsp_pop)   rsp_rd <= rsp_rd + PW'(1);
                rsp_count <= rsp_count + CW'(rsp_push) - CW'(rsp_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant && !flush) pc_mem[pc_wr] <= slot_pc;
        if (rsp_push) begin
            rsp_inst_mem[rsp_wr] <= rsp_inst_w;
            rsp_pc_mem[rsp_wr]   <= rsp_pc_w;
        end
    end

    // A response with nothing outstanding means the memory side broke the protocol.
    rvalid_needs_inflight: assert property (@(posedge clk) disable iff (reset)
        mem_rvalid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_resp.sv
// Directed bench for fetch_resp: expected decode outputs are queued at stimulus time and a monitor compares them.
module tb_fetch_resp;

    logic        clk = 1'b0;
    logic        reset, fetch_req_, fetch_busy, inst_e_, dec_stall, wb_flush_;
    logic        mem_req_, mem_gnt, mem_rvalid;
    logic [31:0] fetch_pc, inst, inst_pc, mem_addr, mem_rdata;
`ifdef FETCH_RESP_MISALIGN_CHK_EN
    logic        inst_misalign;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   failed   = 0;

    always #5 clk = ~clk;

    fetch_resp dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req_ (fetch_req_),
        .fetch_pc   (fetch_pc),
        .fetch_busy (fetch_busy),
        .inst_e_    (inst_e_),
        .inst       (inst),
        .inst_pc    (inst_pc),
`ifdef FETCH_RESP_MISALIGN_CHK_EN
        .inst_misalign (inst_misalign),
`endif
        .dec_stall  (dec_stall),
        .wb_flush_  (wb_flush_),
        .mem_req_   (mem_req_),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [31:0] pc, input logic mis);
        exp_q.push_back('{data: data, pc: pc, mis: mis});
    endtask

    // Request accepted at the next edge, granted at the one after.
    task automatic issue(input logic [31:0] pc);
        check("issue_ready", fetch_busy, 0);
        fetch_req_ = 1'b0;
        fetch_pc   = pc;
        tick();
        fetch_req_ = 1'b1;
        mem_gnt    = 1'b1;
        tick();
        mem_gnt    = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
    endtask

    // Compares the decode head whenever it is consumed at the coming edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !inst_e_ && !dec_stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_inst", inst, e.data);
                    check("sb_inst_pc", inst_pc, e.pc);
`ifdef FETCH_RESP_MISALIGN_CHK_EN
                    check("sb_misalign", inst_misalign, e.mis);
`endif
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; fetch_req_ = 1'b1; fetch_pc = '0; dec_stall = 1'b0; wb_flush_ = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        fork
            monitor();
        join_none
        repeat (2) tick();
        check("rst_mem_req_", mem_req_, 1);
        check("rst_inst_e_", inst_e_, 1);
        check("rst_fetch_busy", fetch_busy, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();

        // Single fetch
        fetch_req_ = 1'b0; fetch_pc = 32'h100;
        tick();
        fetch_req_ = 1'b1;
        check("t1_mem_req_low", mem_req_, 0);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_busy_slot", fetch_busy, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t1_mem_req_released", mem_req_, 1);
        tick();
        check("t1_no_early_inst", inst_e_, 1);
        push_exp(32'h13, 32'h100, 1'b0);
        respond(32'h13);
        check("t1_inst_e_", inst_e_, 0);
        check("t1_inst", inst, 32'h13);
        check("t1_inst_pc", inst_pc, 32'h100);
        tick();
        check("t1_empty", inst_e_, 1);
        check("t1_hold_inst", inst, 32'h13);
        check("t1_hold_pc", inst_pc, 32'h100);
        check("t1_busy_free", fetch_busy, 0);

        // Back-to-back with decode backpressure
        dec_stall = 1'b1;
        issue(32'h0);
        issue(32'h4);
        check("t2_busy_full", fetch_busy, 1);
        push_exp(32'hAAAA0000, 32'h0, 1'b0);
        respond(32'hAAAA0000);
        push_exp(32'hBBBB0004, 32'h4, 1'b0);
        respond(32'hBBBB0004);
        check("t2_head_pc", inst_pc, 32'h0);
        check("t2_busy_buffered", fetch_busy, 1);
        tick();
        check("t2_stall_hold", inst, 32'hAAAA0000);
        dec_stall = 1'b0;
        tick();
        check("t2_busy_after_pop", fetch_busy, 0);
        check("t2_second_pc", inst_pc, 32'h4);
        check("t2_second_valid", inst_e_, 0);
        tick();
        check("t2_drained", inst_e_, 1);

        // Grant delay
        fetch_req_ = 1'b0; fetch_pc = 32'h300;
        tick();
        fetch_req_ = 1'b1; fetch_pc = 32'h555;
        for (int i = 0; i < 3; i++) begin
            check("t3_req_stable", mem_req_, 0);
            check("t3_addr_stable", mem_addr, 32'h300);
            check("t3_busy", fetch_busy, 1);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t3_req_released", mem_req_, 1);
        push_exp(32'hC0DE, 32'h300, 1'b0);
        respond(32'hC0DE);
        check("t3_inst_e_", inst_e_, 0);
        tick();
        check("t3_busy_free", fetch_busy, 0);

        // Flush with two requests in flight
        issue(32'h10);
        issue(32'h14);
        check("t4_busy_before", fetch_busy, 1);
        wb_flush_ = 1'b0; fetch_req_ = 1'b0; fetch_pc = 32'h999;
        tick();
        wb_flush_ = 1'b1; fetch_pc = 32'h200;
        check("t4_flush_req_ignored", mem_req_, 1);
        check("t4_busy_killed_credit", fetch_busy, 1);
        respond(32'hDEAD);
        check("t4_kill1_dropped", inst_e_, 1);
        check("t4_credit_freed", fetch_busy, 0);
        tick();
        fetch_req_ = 1'b1;
        check("t4_new_req", mem_req_, 0);
        check("t4_new_addr", mem_addr, 32'h200);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        respond(32'hBEEF);
        check("t4_kill2_dropped", inst_e_, 1);
        push_exp(32'h213, 32'h200, 1'b0);
        respond(32'h213);
        check("t4_live_pc", inst_pc, 32'h200);
        tick();

        // Reset mid-burst with a buffered response and an ungranted slot
        dec_stall = 1'b1;
        issue(32'h20);
        respond(32'h2020);
        fetch_req_ = 1'b0; fetch_pc = 32'h24;
        tick();
        fetch_req_ = 1'b1;
        check("t5_pre_inst_e_", inst_e_, 0);
        check("t5_pre_mem_req_", mem_req_, 0);
        check("t5_pre_busy", fetch_busy, 1);
        reset = 1'b1;
        tick();
        check("t5_inst_e_", inst_e_, 1);
        check("t5_mem_req_", mem_req_, 1);
        check("t5_busy", fetch_busy, 0);
        check("t5_inst", inst, 0);
        reset = 1'b0; dec_stall = 1'b0;
        tick();
        issue(32'h40);
        push_exp(32'h55, 32'h40, 1'b0);
        respond(32'h55);
        check("t5_after_reset", inst_e_, 0);
        tick();

`ifdef FETCH_RESP_MISALIGN_CHK_EN
        // Misaligned PC behind a pending aligned request
        fetch_req_ = 1'b0; fetch_pc = 32'h100;
        tick();
        fetch_pc = 32'h102;
        check("t6_busy_slot", fetch_busy, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t6_busy_free", fetch_busy, 0);
        tick();
        fetch_req_ = 1'b1;
        check("t6_no_mem_req", mem_req_, 1);
        check("t6_busy_pending", fetch_busy, 1);
        push_exp(32'h77, 32'h100, 1'b0);
        push_exp(32'h0, 32'h102, 1'b1);
        respond(32'h77);
        check("t6_first_pc", inst_pc, 32'h100);
        check("t6_first_mis", inst_misalign, 0);
        tick();
        check("t6_mis_valid", inst_e_, 0);
        check("t6_mis_pc", inst_pc, 32'h102);
        check("t6_mis_flag", inst_misalign, 1);
        check("t6_mis_inst", inst, 0);
        check("t6_still_no_req", mem_req_, 1);
        tick();
        check("t6_busy_end", fetch_busy, 0);
`else
        // Low PC bits are ignored: a misaligned PC still goes to memory
        fetch_req_ = 1'b0; fetch_pc = 32'h102;
        tick();
        fetch_req_ = 1'b1;
        check("t6_mem_req", mem_req_, 0);
        check("t6_mem_addr", mem_addr, 32'h102);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        push_exp(32'h99, 32'h102, 1'b0);
        respond(32'h99);
        tick();
`endif

        repeat (3) tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
